// File: rtl/seq_stream_tx_pkg.sv
// Shared definitions for the seq_stream_tx serialiser.
//   state_t        : FSM state encoding (IDLE/SHIFT/DONE)
//   WIDTH_DEFAULT  : default number of bits per loaded word
package seq_stream_tx_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_stream_piso.sv
// Parallel-in / serial-out data register for seq_stream_tx.
//   clk, rstn : clock, asynchronous active-low reset (clears the register)
//   load      : capture data_in (takes priority over shift)
//   shift     : shift right by one, zero-filling the MSB
//   data_in   : parallel word
//   lsb       : current bit 0 of the register (next bit to emit)
module seq_stream_piso
  import seq_stream_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             lsb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= data_in;
    end else if (shift) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign lsb = shreg[0];

endmodule

// File: rtl/seq_stream_tx.sv
// Word serialiser: accepts a WIDTH-bit word and emits it LSB first, one bit
// per cycle, with a stall input, an end-of-word pulse and a running modulo-4
// count of emitted one bits.
//   clk, rstn : clock, asynchronous active-low reset
//   load      : accept data_in (only while ready=1)
//   data_in   : word to serialise
//   hold      : freeze serialisation for this cycle (ignored outside SHIFT)
//   clr       : synchronous clear of ones_cnt, beats a same-edge increment
//   ready     : idle and able to take a word
//   x_out     : serial bit (0 whenever x_valid=0)
//   x_valid   : x_out carries a payload bit this cycle
//   done      : one-cycle pulse in the first IDLE cycle after a word
//   ones_cnt  : emitted one bits, modulo 4, persistent across words
//
// Handshake: a word transfers on a rising edge where load=1 and ready=1;
// load with ready=0 is dropped and has no effect. There is no backpressure
// on the serial side: x_valid=1 means a bit is delivered in that cycle.
module seq_stream_tx
  import seq_stream_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             hold,
  input  logic             clr,
  output logic             ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             done,
  output logic [1:0]       ones_cnt
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t          state, state_d;
  logic [CW-1:0]   bit_cnt, bit_cnt_d;
  logic            x_out_d, x_valid_d, done_d;
  logic [1:0]      ones_d;
  logic            piso_load, piso_shift, piso_lsb;
  logic            last_bit;

  seq_stream_piso #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .rstn    (rstn),
    .load    (piso_load),
    .shift   (piso_shift),
    .data_in (data_in),
    .lsb     (piso_lsb)
  );

  assign ready    = (state == IDLE);
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  // All outputs are registered: the comb block computes their next values.
  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    x_out_d    = 1'b0;
    x_valid_d  = 1'b0;
    done_d     = 1'b0;
    ones_d     = ones_cnt;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    case (state)
      IDLE: begin
        if (load) begin
          piso_load = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          piso_shift = 1'b1;
          x_out_d    = piso_lsb;
          x_valid_d  = 1'b1;
          bit_cnt_d  = bit_cnt + CW'(1);
          if (piso_lsb) begin
            ones_d = ones_cnt + 2'd1;
          end
          if (last_bit) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr) begin
      ones_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      x_out    <= 1'b0;
      x_valid  <= 1'b0;
      done     <= 1'b0;
      ones_cnt <= 2'd0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      x_out    <= x_out_d;
      x_valid  <= x_valid_d;
      done     <= done_d;
      ones_cnt <= ones_d;
    end
  end

endmodule

// File: tb/tb_seq_stream_tx.sv
// Testbench for seq_stream_tx (WIDTH=8). Inputs change on the falling edge,
// outputs are sampled on the following falling edge. Each sampled cycle is
// compared as a record {ready, x_valid, x_out, done, ones_cnt}.
module tb_seq_stream_tx;

  localparam int W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         load = 1'b0;
  logic         hold = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ready, x_out, x_valid, done;
  logic [1:0]   ones_cnt;

  always #5 clk = ~clk;

  seq_stream_tx #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .data_in  (data_in),
    .hold     (hold),
    .clr      (clr),
    .ready    (ready),
    .x_out    (x_out),
    .x_valid  (x_valid),
    .done     (done),
    .ones_cnt (ones_cnt)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [1:0] ones_m;        // reference modulo-4 count of emitted ones
  logic       exp_q[$];      // expected serial bits, LSB of each word first

  typedef struct {
    logic         l;
    logic [W-1:0] d;
    logic         h;
    logic         c;
    logic [5:0]   e;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [5:0] rec(logic r, logic v, logic o, logic dn, logic [1:0] n);
    return {r, v, o, dn, n};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {ready, x_valid, x_out, done, ones_cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rdy/vld/out/done/ones got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs, let one rising edge pass, compare outputs.
  task automatic cyc(input logic l, input logic [W-1:0] d, input logic h, input logic c,
                     input logic [5:0] e, input string name);
    load = l; data_in = d; hold = h; clr = c;
    @(posedge clk);
    @(negedge clk);
    check(name, e);
  endtask

  // Same, with ones_cnt taken from the reference counter.
  task automatic mcyc(input logic l, input logic [W-1:0] d, input logic h, input logic c,
                      input logic r, input logic v, input logic o, input logic dn,
                      input string name);
    if (c) ones_m = 2'd0;
    else if (v && o) ones_m = ones_m + 2'd1;
    cyc(l, d, h, c, rec(r, v, o, dn, ones_m), name);
  endtask

  // Asynchronous reset between clock edges; outputs checked before any edge.
  task automatic do_reset(input string name);
    load = 1'b0; hold = 1'b0; clr = 1'b0; data_in = '0;
    rstn = 1'b0;
    #2;
    check(name, rec(1, 0, 0, 0, 0));
    #1 rstn = 1'b1;
    @(negedge clk);
    ones_m = 2'd0;
  endtask

  // Emit all bits of w with no stalls, then the done cycle. A stray load
  // (with different data) is offered at bit index noise_at.
  task automatic shift_word(input logic [W-1:0] w, input int noise_at, input string name);
    for (int i = 0; i < W; i++) begin
      mcyc(i == noise_at, ~w, 1'b0, 1'b0, 1'b0, 1'b1, w[i], 1'b0,
           $sformatf("%s_bit%0d", name, i));
    end
    mcyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {name, "_done"});
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] word;
    logic [W-1:0] rd;
    logic         b, h, nl, rc;
    int           gap;

    #1;
    do_reset("reset_initial");

    // Word 8'hB5 with no stalls; a stray load mid-word and a hold in the
    // DONE cycle must both be ignored.
    vecs[0]  = '{1'b1, 8'hB5, 1'b0, 1'b0, rec(0, 0, 0, 0, 0)};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, rec(0, 1, 1, 0, 1)};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, rec(0, 1, 0, 0, 1)};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, rec(0, 1, 1, 0, 2)};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, rec(0, 1, 0, 0, 2)};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, rec(0, 1, 1, 0, 3)};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, rec(0, 1, 1, 0, 0)};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, rec(0, 1, 0, 0, 0)};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, rec(0, 1, 1, 0, 1)};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, rec(1, 0, 0, 1, 1)};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, rec(1, 0, 0, 0, 1)};
    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].l, vecs[i].d, vecs[i].h, vecs[i].c, vecs[i].e, $sformatf("b5_vec%0d", i));
    end

    // 8'hFF with a 3-cycle stall after the second bit; done 12 edges after load.
    do_reset("reset_hold");
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, rec(0, 0, 0, 0, 0), "hold_load");
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, rec(0, 1, 1, 0, 2'((i + 1) % 4)), $sformatf("hold_bit%0d", i));
      if (i == 1) begin
        for (int k = 0; k < 3; k++) begin
          cyc(1'b0, '0, 1'b1, 1'b0, rec(0, 0, 0, 0, 2), $sformatf("hold_stall%0d", k));
        end
      end
    end
    cyc(1'b0, '0, 1'b0, 1'b0, rec(1, 0, 0, 1, 0), "hold_done");

    // Back-to-back: 8'h0F, then 8'hAA loaded in the done cycle.
    do_reset("reset_b2b");
    mcyc(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_load0");
    shift_word(8'h0F, 3, "b2b_w0");
    mcyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_load1");
    shift_word(8'hAA, 5, "b2b_w1");
    cyc(1'b0, '0, 1'b0, 1'b0, rec(1, 0, 0, 0, 0), "b2b_ones_final");

    // clr on the edge emitting a 1 while ones_cnt=2.
    do_reset("reset_clr");
    cyc(1'b1, 8'h07, 1'b0, 1'b0, rec(0, 0, 0, 0, 0), "clr_load");
    cyc(1'b0, '0, 1'b0, 1'b0, rec(0, 1, 1, 0, 1), "clr_bit0");
    cyc(1'b0, '0, 1'b0, 1'b0, rec(0, 1, 1, 0, 2), "clr_bit1");
    cyc(1'b0, '0, 1'b0, 1'b1, rec(0, 1, 1, 0, 0), "clr_bit2");
    for (int i = 3; i < W; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, rec(0, 1, 0, 0, 0), $sformatf("clr_bit%0d", i));
    end
    cyc(1'b0, '0, 1'b0, 1'b0, rec(1, 0, 0, 1, 0), "clr_done");

    // Reset after the 4th bit of 8'hC3: no done pulse, then a clean word.
    do_reset("reset_c3");
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, rec(0, 0, 0, 0, 0), "c3_load");
    cyc(1'b0, '0, 1'b0, 1'b0, rec(0, 1, 1, 0, 1), "c3_bit0");
    cyc(1'b0, '0, 1'b0, 1'b0, rec(0, 1, 1, 0, 2), "c3_bit1");
    cyc(1'b0, '0, 1'b0, 1'b0, rec(0, 1, 0, 0, 2), "c3_bit2");
    cyc(1'b0, '0, 1'b0, 1'b0, rec(0, 1, 0, 0, 2), "c3_bit3");
    do_reset("reset_midword");
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, rec(1, 0, 0, 0, 0), $sformatf("c3_post_reset%0d", k));
    end
    mcyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "r01_load");
    shift_word(8'h01, -1, "r01");

    // Randomised words, stalls, stray loads and clears against the model.
    do_reset("reset_rand");
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      word = W'($urandom);
      gap  = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rd = W'($urandom);
        h  = 1'($urandom_range(0, 1));
        rc = ($urandom_range(0, 7) == 0);
        mcyc(1'b0, rd, h, rc, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d_gap", n));
      end
      rc = ($urandom_range(0, 7) == 0);
      h  = 1'($urandom_range(0, 1));
      mcyc(1'b1, word, h, rc, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d_load", n));
      for (int i = 0; i < W; i++) exp_q.push_back(word[i]);
      while (exp_q.size() > 0) begin
        h  = ($urandom_range(0, 3) == 0);
        nl = ($urandom_range(0, 3) == 0);
        rc = ($urandom_range(0, 7) == 0);
        rd = W'($urandom);
        if (h) begin
          mcyc(nl, rd, 1'b1, rc, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d_stall", n));
        end else begin
          b = exp_q.pop_front();
          mcyc(nl, rd, 1'b0, rc, 1'b0, 1'b1, b, 1'b0, $sformatf("rnd%0d_bit", n));
        end
      end
      rc = ($urandom_range(0, 7) == 0);
      nl = 1'($urandom_range(0, 1));
      h  = 1'($urandom_range(0, 1));
      rd = W'($urandom);
      mcyc(nl, rd, h, rc, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("rnd%0d_done", n));
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
